// File: rtl/alu_pkg.sv
// Shared opcode map and FSM state encoding for the ALU family.
// The combinational alu and the multi-cycle alu_mc both use it.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Codes above MULHU are unassigned.
    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_MULHU;
    endfunction

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: bit 0 of b is folded in on the start edge,
// then one multiplier bit per cycle; done marks the edge the counter reaches WIDTH-1.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               busy;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    // product is the accumulator including the final partial, valid while done is high.
    assign product  = acc_next;
    assign done     = busy && (cnt == CW'(WIDTH - 2));

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a} << 1;
            mplier <= b >> 1;
            acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle ops complete on the
// accepting edge, MUL/MULHU run on the iterative multiplier; result held in HOLD.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             illegal
);

    state_t               state;
    logic                 mul_hi;
    logic                 accept;
    logic                 start_mul;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     res;
    logic [WIDTH-1:0]     mul_res;
    logic [SHW-1:0]       shamt;

    assign in_ready  = !rst && ((state == ST_IDLE && !out_valid) || (out_valid && out_ready));
    assign accept    = in_valid && in_ready;
    assign start_mul = accept && is_mul_op(sel);
    assign shamt     = b[SHW-1:0];
    assign mul_res   = mul_hi ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves res unassigned (no latch).
        res = '0;
        case (sel)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_XOR:  res = a ^ b;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, a < b};
            OP_SLL:  res = a << shamt;
            OP_SRL:  res = a >> shamt;
            OP_SRA:  res = $unsigned($signed(a) >>> shamt);
            default: res = '0;
        endcase
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (start_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out       <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
            mul_hi    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        if (is_mul_op(sel)) begin
                            // out keeps its old value; only out_valid drops until the product lands.
                            state     <= ST_MUL;
                            out_valid <= 1'b0;
                            mul_hi    <= (sel == OP_MULHU);
                        end else begin
                            state     <= ST_HOLD;
                            out       <= res;
                            zero      <= (res == '0);
                            illegal   <= is_illegal(sel);
                            out_valid <= 1'b1;
                        end
                    end else if (state == ST_HOLD && out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state     <= ST_HOLD;
                        out       <= mul_res;
                        zero      <= (mul_res == '0);
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc at WIDTH=32 (scoreboard + directed sequences)
// and WIDTH=8 (direct vector loop).
module tb_alu_mc;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // WIDTH=32 instance
    logic        rst, in_valid, in_ready, out_valid, out_ready, zero, illegal;
    logic [31:0] a, b, out;
    logic [3:0]  sel;

    // WIDTH=8 instance
    logic        rst8, in_valid8, in_ready8, out_valid8, out_ready8, zero8, illegal8;
    logic [7:0]  a8, b8, out8;
    logic [3:0]  sel8;

    alu_mc #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zero(zero), .illegal(illegal)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sel(sel8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out(out8), .zero(zero8), .illegal(illegal8)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [31:0] out;
        logic        z;
        logic        il;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] out;
        logic        z;
        logic        il;
        int          lat;
        int          offer;
    } exp_t;

    exp_t sb[$];
    vec_t v32[19];
    vec_t v8[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares on each consumption, measures offer-to-valid latency.
    bit pending = 1'b0;
    int vstart  = 0;
    always @(negedge clk) begin
        if (rst) begin
            pending = 1'b0;
        end else begin
            if (out_valid && !pending) begin
                vstart  = cyc;
                pending = 1'b1;
            end
            if (!out_valid) pending = 1'b0;
            if (out_valid && out_ready) begin
                pending = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual_out=%0h expected=no_result", out);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_out", 64'(out), 64'(e.out));
                    check("sb_zero", 64'(zero), 64'(e.z));
                    check("sb_illegal", 64'(illegal), 64'(e.il));
                    if (e.lat > 0) check("sb_latency", 64'(vstart - e.offer), 64'(e.lat));
                end
            end
        end
    end

    task automatic send(input logic [31:0] ta, input logic [31:0] tb_b, input logic [3:0] ts,
                        input logic [31:0] eo, input logic ez, input logic ei, input int lat);
        bit ok = 1'b0;
        a = ta; b = tb_b; sel = ts; in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                sb.push_back('{out: eo, z: ez, il: ei, lat: lat, offer: cyc});
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL send_timeout actual=not_accepted expected=accepted sel=%0h", ts);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain actual_pending=%0d expected=0", name, sb.size());
        end
    endtask

    task automatic run8(input vec_t v, input int idx);
        bit ok  = 1'b0;
        bit got = 1'b0;
        int off = 0;
        a8 = v.a[7:0]; b8 = v.b[7:0]; sel8 = v.sel; in_valid8 = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready8) begin ok = 1'b1; off = cyc; end
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        for (int i = 0; i < 50 && ok && !got; i++) begin
            @(negedge clk);
            if (out_valid8) got = 1'b1;
        end
        if (!ok || !got) begin
            checks++; failures++;
            $display("FAIL w8_%0d_timeout actual=accepted:%0d,valid:%0d expected=1,1", idx, ok, got);
        end else begin
            check($sformatf("w8_%0d_out", idx), 64'(out8), 64'(v.out[7:0]));
            check($sformatf("w8_%0d_zero", idx), 64'(zero8), 64'(v.z));
            check($sformatf("w8_%0d_illegal", idx), 64'(illegal8), 64'(v.il));
            check($sformatf("w8_%0d_latency", idx), 64'(cyc - off), 64'(v.lat));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] xa[4];
        logic [31:0] xb[4];
        int bad;
        bit seen;

        v32[0]  = '{32'd7,        32'd5,        OP_ADD,   32'd12,       1'b0, 1'b0, 1};
        v32[1]  = '{32'd15,       32'd9,        OP_SUB,   32'd6,        1'b0, 1'b0, 1};
        v32[2]  = '{32'hFFFFFFFC, 32'd2,        OP_SLT,   32'd1,        1'b0, 1'b0, 1};
        v32[3]  = '{32'hFFFFFFFC, 32'd2,        OP_SLTU,  32'd0,        1'b1, 1'b0, 1};
        v32[4]  = '{32'hFFFFFFF8, 32'd2,        OP_SRA,   32'hFFFFFFFE, 1'b0, 1'b0, 1};
        v32[5]  = '{32'hF0F0F0F0, 32'hFF00FF00, OP_AND,   32'hF000F000, 1'b0, 1'b0, 1};
        v32[6]  = '{32'h0F0F0000, 32'h000000F0, OP_OR,    32'h0F0F00F0, 1'b0, 1'b0, 1};
        v32[7]  = '{32'hAAAA5555, 32'hAAAA5555, OP_XOR,   32'd0,        1'b1, 1'b0, 1};
        v32[8]  = '{32'h80000000, 32'h0000003F, OP_SRL,   32'd1,        1'b0, 1'b0, 1};
        v32[9]  = '{32'd1,        32'h00000021, OP_SLL,   32'd2,        1'b0, 1'b0, 1};
        v32[10] = '{32'd0,        32'd1,        OP_SUB,   32'hFFFFFFFF, 1'b0, 1'b0, 1};
        v32[11] = '{32'hFFFFFFFF, 32'd1,        OP_ADD,   32'd0,        1'b1, 1'b0, 1};
        v32[12] = '{32'd5,        32'd6,        4'b1110,  32'd0,        1'b1, 1'b1, 1};
        v32[13] = '{32'd5,        32'd6,        4'b1100,  32'd0,        1'b1, 1'b1, 1};
        v32[14] = '{32'h00010000, 32'h00010000, OP_MUL,   32'd0,        1'b1, 1'b0, 32};
        v32[15] = '{32'h00010000, 32'h00010000, OP_MULHU, 32'd1,        1'b0, 1'b0, 32};
        v32[16] = '{32'hFFFFFFFF, 32'hFFFFFFFF, OP_MUL,   32'd1,        1'b0, 1'b0, 32};
        v32[17] = '{32'hFFFFFFFF, 32'hFFFFFFFF, OP_MULHU, 32'hFFFFFFFE, 1'b0, 1'b0, 32};
        v32[18] = '{32'd2,        32'hFFFFFFFC, OP_SLT,   32'd0,        1'b1, 1'b0, 1};

        v8[0] = '{32'd7,   32'd5,  OP_ADD,   32'd12,  1'b0, 1'b0, 1};
        v8[1] = '{32'd15,  32'd9,  OP_SUB,   32'd6,   1'b0, 1'b0, 1};
        v8[2] = '{32'hFC,  32'd2,  OP_SLT,   32'd1,   1'b0, 1'b0, 1};
        v8[3] = '{32'hFC,  32'd2,  OP_SLTU,  32'd0,   1'b1, 1'b0, 1};
        v8[4] = '{32'hF8,  32'd2,  OP_SRA,   32'hFE,  1'b0, 1'b0, 1};
        v8[5] = '{32'd1,   32'd4,  OP_SLL,   32'd16,  1'b0, 1'b0, 1};
        v8[6] = '{32'd1,   32'd9,  OP_SLL,   32'd2,   1'b0, 1'b0, 1};
        v8[7] = '{32'h10,  32'h10, OP_MUL,   32'd0,   1'b1, 1'b0, 8};
        v8[8] = '{32'h10,  32'h10, OP_MULHU, 32'd1,   1'b0, 1'b0, 8};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sel = '0;
        rst8 = 1'b1; in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; sel8 = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; rst8 = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out", 64'(out), 64'd0);
        check("reset_zero", 64'(zero), 64'd0);
        check("reset_illegal", 64'(illegal), 64'd0);
        check("reset_in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Vector table, out_ready tied high
        for (int i = 0; i < 19; i++) begin
            send(v32[i].a, v32[i].b, v32[i].sel, v32[i].out, v32[i].z, v32[i].il, v32[i].lat);
            drain($sformatf("v32_%0d", i));
        end

        // MUL: in_ready stays low until the product appears
        send(32'h00010000, 32'h00010000, OP_MUL, 32'd0, 1'b1, 1'b0, 32);
        bad = 0; seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else if (in_ready) bad++;
        end
        check("mul_in_ready_low_cycles", 64'(bad), 64'd0);
        @(posedge clk); #1;
        drain("mul_ready");

        // Backpressure: ADD 3+4 held while out_ready low, second offer waits
        out_ready = 1'b0;
        send(32'd3, 32'd4, OP_ADD, 32'd7, 1'b0, 1'b0, 0);
        a = 32'd1; b = 32'd2; sel = OP_ADD; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_%0d_out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("bp_%0d_out", i), 64'(out), 64'd7);
            check($sformatf("bp_%0d_zero", i), 64'(zero), 64'd0);
            check($sformatf("bp_%0d_in_ready", i), 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        sb.push_back('{out: 32'd3, z: 1'b0, il: 1'b0, lat: 0, offer: cyc});
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain("backpressure");

        // Back-to-back XOR stream
        xa[0] = 32'h12345678; xb[0] = 32'h0F0F0F0F;
        xa[1] = 32'hFFFF0000; xb[1] = 32'hFFFF0000;
        xa[2] = 32'h80000001; xb[2] = 32'h00000001;
        xa[3] = 32'hDEADBEEF; xb[3] = 32'hFFFFFFFF;
        a = xa[0]; b = xb[0]; sel = OP_XOR; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("b2b_%0d_in_ready", i), 64'(in_ready), 64'd1);
            sb.push_back('{out: xa[i] ^ xb[i], z: (xa[i] == xb[i]), il: 1'b0, lat: 1, offer: cyc});
            if (i > 0) begin
                check($sformatf("b2b_%0d_out_valid", i - 1), 64'(out_valid), 64'd1);
                check($sformatf("b2b_%0d_out", i - 1), 64'(out), 64'(xa[i-1] ^ xb[i-1]));
            end
            @(posedge clk); #1;
            if (i < 3) begin a = xa[i+1]; b = xb[i+1]; end
            else in_valid = 1'b0;
        end
        @(negedge clk);
        check("b2b_3_out_valid", 64'(out_valid), 64'd1);
        check("b2b_3_out", 64'(out), 64'(xa[3] ^ xb[3]));
        @(posedge clk); #1;
        drain("b2b");

        // Reset in the middle of a MUL: no result, back to IDLE
        send(32'd123, 32'd456, OP_MUL, 32'd56088, 1'b0, 1'b0, 32);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midmul_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midmul_out_valid", 64'(out_valid), 64'd0);
        check("midmul_out", 64'(out), 64'd0);
        check("midmul_idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        repeat (40) @(posedge clk);
        #1;
        send(32'd1, 32'd1, OP_ADD, 32'd2, 1'b0, 1'b0, 1);
        drain("after_rst");

        // WIDTH=8 instance
        for (int i = 0; i < 9; i++) run8(v8[i], i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal: 8, 16, 32, 64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width taken from b[SHW-1:0].
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand/opcode offer.
REQ-006 SHALL have port in_ready  output  1  block accepts the offer this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port sel  input  4  opcode.
REQ-010 SHALL have port out_valid  output  1  result held and valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port out  output  WIDTH  registered result.
REQ-013 SHALL have port zero  output  1  out == 0, registered with out.
REQ-014 SHALL have port illegal  output  1  sel was an unassigned code, registered with out.

Function
REQ-015 SHALL decode sel: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR, 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits, unsigned); 1100-1111 illegal.
REQ-016 SHALL wrap ADD/SUB modulo 2^WIDTH; no carry/overflow output.
REQ-017 SHALL return 1 or 0 zero-extended to WIDTH for SLT/SLTU.
REQ-018 SHALL use only b[SHW-1:0] as shift amount; SRA replicates a[WIDTH-1].
REQ-019 SHALL run FSM states IDLE, MUL, HOLD.
REQ-020 SHALL drive in_ready = 1 only in IDLE with out_valid low, or out_valid high and out_ready high in the same cycle.
REQ-021 SHALL accept on in_valid && in_ready; operands and sel captured at that edge.
REQ-022 SHALL, for single-cycle and illegal ops, load out/zero/illegal and set out_valid at the accepting edge (latency 1), state HOLD.
REQ-023 SHALL, for illegal ops, load out = 0, zero = 1, illegal = 1.
REQ-024 SHALL, for MUL/MULHU, enter MUL and perform shift-add over 2*WIDTH-bit accumulator, one multiplier bit per cycle, iteration counter 0..WIDTH-1.
REQ-025 SHALL load out and set out_valid on the edge the counter reaches WIDTH-1, i.e. out_valid rises WIDTH cycles after acceptance; state HOLD.
REQ-026 SHALL hold out/zero/illegal/out_valid stable in HOLD while out_ready low.
REQ-027 SHALL, in HOLD with out_ready high: if in_valid, accept next op same edge (back-to-back single-cycle throughput 1/cycle); else clear out_valid, go IDLE.
REQ-028 SHALL ignore in_valid while in MUL (in_ready = 0); a MUL accepted in HOLD clears out_valid until its result loads.
REQ-029 SHALL never change out or out_valid except on acceptance-completion or consumption edges.

Reset
REQ-030 SHALL, with rst high at an edge, force state IDLE, counter 0, accumulator 0, out 0, zero 0, illegal 0, out_valid 0; in_ready low during the reset cycle.
REQ-031 SHALL abort an in-flight MUL on rst with no result produced; reset dominates all simultaneous handshakes.

Structure
REQ-032 SHALL place opcode localparams (OP_AND..OP_MULHU) and FSM state encoding in shared package alu_pkg, reused by the legacy combinational alu.
REQ-033 SHALL implement the iterative multiplier as sub-module alu_mul_iter (WIDTH param, start/done, 2*WIDTH product); single-cycle ops are inline combinational logic.

Verification
REQ-034 SHALL test WIDTH=32 single ops, out_ready tied high: ADD 7+5 -> 12; SUB 15-9 -> 6; SLT -4,2 -> 1; SLTU 0xFFFFFFFC,2 -> 0; SRA -8>>>2 -> 0xFFFFFFFE; each out_valid one cycle after acceptance.
REQ-035 SHALL test MUL 0x10000,0x10000 -> out 0, zero 1; MULHU same -> 1; out_valid exactly 32 cycles after acceptance, in_ready low throughout.
REQ-036 SHALL test backpressure: ADD 3+4 with out_ready low 5 cycles -> out 7 held stable, in_ready low, second offer not taken until out_ready rises.
REQ-037 SHALL test back-to-back: 4 consecutive XOR ops with in_valid/out_ready high -> 4 results on 4 consecutive cycles, in order.
REQ-038 SHALL test illegal sel 1110 -> out 0, zero 1, illegal 1; and rst asserted mid-MUL (cycle 10) -> out_valid 0, IDLE, next ADD 1+1 -> 2.
REQ-039 SHALL rerun REQ-034 at WIDTH=8: SLL 1<<4 -> 16, SLL by b=9 uses b[2:0]=1 -> 2.
